// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline encodings.
// Result-source selects, load funct3 codes and writeback FSM states.
package riscv_pkg;

  localparam logic [1:0] RES_ALU  = 2'b00;
  localparam logic [1:0] RES_LOAD = 2'b01;
  localparam logic [1:0] RES_PC4  = 2'b10;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    LOAD_WAIT = 1'b1
  } wb_state_t;

endpackage

// File: rtl/load_align.sv
// Load data lane select and sign/zero extension.
// Also flags misaligned addresses and funct3 codes that are not loads.
module load_align
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] data,
  output logic            bad
);

  logic [7:0]  b;
  logic [15:0] h;

  assign b = rdata[{addr, 3'b000} +: 8];
  assign h = rdata[{addr[1], 4'b0000} +: 16];

  always_comb begin
    data = '0;
    bad  = 1'b0;
    unique case (1'b1)
      (funct3 == F3_LB):  data = {{(XLEN-8){b[7]}}, b};
      (funct3 == F3_LBU): data = {{(XLEN-8){1'b0}}, b};
      (funct3 == F3_LH): begin
        data = {{(XLEN-16){h[15]}}, h};
        bad  = addr[0];
      end
      (funct3 == F3_LHU): begin
        data = {{(XLEN-16){1'b0}}, h};
        bad  = addr[0];
      end
      (funct3 == F3_LW): begin
        data = rdata;
        bad  = (addr != 2'b00);
      end
      default: bad = 1'b1;
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: retires MEM results, runs data loads over req/ack,
// drives the register-file write port and mirrors it as a forwarding tap.
module writeback_unit
  import riscv_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TIMEOUT_W      = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic            in_reg_write,
  input  logic [4:0]      in_rd,
  input  logic [1:0]      in_result_src,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_alu_result,
  input  logic [XLEN-1:0] in_pc_plus4,
  input  logic            flush,
  output logic            stall_out,
  output logic            dm_req,
  output logic [XLEN-1:0] dm_addr,
  input  logic            dm_ack,
  input  logic [XLEN-1:0] dm_rdata,
  output logic            rf_we,
  output logic [4:0]      rf_a3,
  output logic [XLEN-1:0] rf_wd,
  output logic            fwd_valid,
  output logic [4:0]      fwd_rd,
  output logic [XLEN-1:0] fwd_data,
  output logic            misalign_err,
  output logic            bus_err
);

  localparam bit HAS_TO = (TIMEOUT_CYCLES != 0);
  localparam logic [TIMEOUT_W:0] LIMIT =
    (TIMEOUT_W+1)'(TIMEOUT_CYCLES);

  wb_state_t state, state_d;

  logic [TIMEOUT_W-1:0] cnt, cnt_d;
  logic [TIMEOUT_W:0]   cnt_nxt;
  logic [4:0]           lat_rd, lat_rd_d;
  logic                 lat_we, lat_we_d;
  logic [2:0]           lat_f3, lat_f3_d;
  logic [1:0]           lat_a, lat_a_d;

  logic            rf_we_d, dm_req_d;
  logic            mis_d, bus_d;
  logic [4:0]      rf_a3_d;
  logic [XLEN-1:0] rf_wd_d, dm_addr_d;

  logic            accept, is_load;
  logic            load_go, load_bad;
  logic            timeout_hit;
  logic [2:0]      al_f3;
  logic [1:0]      al_a;
  logic [XLEN-1:0] al_data;
  logic            al_bad;

  assign stall_out = (state == LOAD_WAIT);

  assign accept  = (state == IDLE) & in_valid & ~flush;
  assign is_load = (in_result_src == RES_LOAD);

  // One aligner: checks the incoming load in IDLE, extracts data in LOAD_WAIT.
  assign al_f3 = stall_out ? lat_f3 : in_funct3;
  assign al_a  = stall_out ? lat_a  : in_alu_result[1:0];

  load_align #(.XLEN(XLEN)) u_align (
    .funct3 (al_f3),
    .addr   (al_a),
    .rdata  (dm_rdata),
    .data   (al_data),
    .bad    (al_bad)
  );

  assign load_go  = accept & is_load & ~al_bad;
  assign load_bad = accept & is_load & al_bad;

  assign cnt_nxt     = {1'b0, cnt} + 1'b1;
  assign timeout_hit = HAS_TO & ~dm_ack & (cnt_nxt == LIMIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:      if (load_go) state_d = LOAD_WAIT;
      LOAD_WAIT: if (dm_ack || timeout_hit) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    rf_we_d   = 1'b0;
    rf_a3_d   = rf_a3;
    rf_wd_d   = rf_wd;
    dm_req_d  = dm_req;
    dm_addr_d = dm_addr;
    mis_d     = 1'b0;
    bus_d     = 1'b0;
    cnt_d     = cnt;
    lat_rd_d  = lat_rd;
    lat_we_d  = lat_we;
    lat_f3_d  = lat_f3;
    lat_a_d   = lat_a;
    unique case (state)
      IDLE: begin
        if (accept && !is_load) begin
          rf_we_d = in_reg_write & (in_rd != 5'd0);
          rf_a3_d = in_rd;
          rf_wd_d = (in_result_src == RES_PC4) ?
                    in_pc_plus4 : in_alu_result;
        end else if (load_go) begin
          dm_req_d  = 1'b1;
          dm_addr_d = {in_alu_result[XLEN-1:2], 2'b00};
          cnt_d     = '0;
          lat_rd_d  = in_rd;
          lat_we_d  = in_reg_write;
          lat_f3_d  = in_funct3;
          lat_a_d   = in_alu_result[1:0];
        end else if (load_bad) begin
          mis_d = 1'b1;
        end
      end
      LOAD_WAIT: begin
        if (dm_ack) begin
          dm_req_d = 1'b0;
          rf_we_d  = lat_we & (lat_rd != 5'd0);
          rf_a3_d  = lat_rd;
          rf_wd_d  = al_data;
        end else if (timeout_hit) begin
          dm_req_d = 1'b0;
          bus_d    = 1'b1;
        end else begin
          cnt_d = cnt_nxt[TIMEOUT_W-1:0];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_we        <= 1'b0;
      rf_a3        <= '0;
      rf_wd        <= '0;
      dm_req       <= 1'b0;
      dm_addr      <= '0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
      cnt          <= '0;
      lat_rd       <= '0;
      lat_we       <= 1'b0;
      lat_f3       <= '0;
      lat_a        <= '0;
    end else begin
      rf_we        <= rf_we_d;
      rf_a3        <= rf_a3_d;
      rf_wd        <= rf_wd_d;
      dm_req       <= dm_req_d;
      dm_addr      <= dm_addr_d;
      misalign_err <= mis_d;
      bus_err      <= bus_d;
      cnt          <= cnt_d;
      lat_rd       <= lat_rd_d;
      lat_we       <= lat_we_d;
      lat_f3       <= lat_f3_d;
      lat_a        <= lat_a_d;
    end
  end

  assign fwd_valid = rf_we;
  assign fwd_rd    = rf_a3;
  assign fwd_data  = rf_wd;

endmodule
